main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multicycle main controller for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, and supplies the 2-bit `alu_op` consumed by the ALU decoder. It stalls on a memory ready handshake and traps permanently on unsupported opcodes.

## Interface
Parameters:
- none. All encodings come from the shared package.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  rising-edge clock.
  - `reset`  in  1  synchronous, active-high.
- Instruction and flag inputs:
  - `opcode`  in  7  instr[6:0], valid from DECODE onward.
  - `funct3`  in  3  instr[14:12].
  - `zero`  in  1  ALU zero flag.
  - `mem_ready`  in  1  memory completes the current access this cycle.
- Write enables:
  - `pc_write`  out  1  PC register load.
  - `ir_write`  out  1  instruction and old-PC register load.
  - `mem_write`  out  1  store request.
  - `reg_write`  out  1  register file write.
- Datapath selects:
  - `adr_src`  out  1  memory address: 0 = PC, 1 = ALU-out register.
  - `alu_src_a`  out  2  00 = PC, 01 = old PC, 10 = rs1.
  - `alu_src_b`  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
  - `result_src`  out  2  00 = ALU-out register, 01 = read data, 10 = live ALU result.
  - `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
  - `imm_src`  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- Status:
  - `instr_done`  out  1  one-cycle retire pulse.
  - `illegal`  out  1  trap flag, sticky until reset.

## Operation
- Default for every output: 0. Each state asserts only what is listed.
- FETCH:
  - Drives `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - While `mem_ready`=0: no enables asserted, stay in FETCH.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 (PC+4), go to DECODE.
- DECODE:
  - Drives `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00, which precomputes PC+imm.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - anything else -> TRAP.
- MEMADR: drives `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: drives `adr_src`=1. Stay while `mem_ready`=0; on `mem_ready`=1 go to MEMWB.
- MEMWB: drives `result_src`=01, `reg_write`=1. Go to FETCH.
- MEMWRITE: drives `adr_src`=1, `mem_write`=1, held until `mem_ready`=1. Then go to FETCH.
- EXECR: drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Go to ALUWB.
- EXECI: drives `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Go to ALUWB.
- ALUWB: drives `result_src`=00, `reg_write`=1. Go to FETCH.
- BRANCH:
  - Drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` when `funct3`=000 (beq), `!zero` when `funct3`=001 (bne).
  - `funct3` 000 or 001 -> FETCH. Any other `funct3` -> TRAP with `pc_write`=0.
- JAL:
  - Drives `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00.
  - `pc_write`=1, which loads the target held in the ALU-out register. Go to ALUWB, which writes PC+4 to rd.
- TRAP: `illegal`=1, all enables 0. Stays in TRAP until `reset`.
- `imm_src` is a combinational function of `opcode` alone: I-type and load 00, store 01, branch 10, jal 11, otherwise 00.
- `instr_done`=1 in every cycle whose next state is FETCH from a non-FETCH state.

## Timing
- Reset: the state becomes FETCH at the first edge with `reset`=1. While `reset`=1, all write enables, `instr_done` and `illegal` are forced to 0 combinationally.
- `reset` asserted mid-instruction aborts it; no partial writes occur after that edge.
- All outputs are Moore decodes of the state, except:
  - `pc_write` in FETCH depends on `mem_ready`.
  - `ir_write` depends on `mem_ready`.
  - `pc_write` in BRANCH depends on `zero` and `funct3`.
- Cycles per instruction with zero wait states:
  - R / I: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - jal: 4.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_ready` seen outside FETCH, MEMREAD and MEMWRITE is ignored.

## Structure
- Shared package `core_ctrl_pkg` holds:
  - the state enum, 4-bit encoding;
  - opcode constants;
  - `ALU_OP_ADD`/`ALU_OP_SUB`/`ALU_OP_FUNCT`;
  - the `alu_src_a`, `alu_src_b`, `result_src` and `imm_src` select encodings.
- One sub-module, `imm_src_decoder`: combinational opcode -> `imm_src`.
- The FSM itself uses one state register, a next-state block and an output decode block.

## Test plan
- `add x3,x1,x2`, `mem_ready` tied 1: states FETCH, DECODE, EXECR, ALUWB over 4 cycles. `alu_op`=10 in EXECR; `reg_write`=1 and `instr_done`=1 in ALUWB.
- lw with `mem_ready` low 2 cycles in MEMREAD: total 7 cycles. `reg_write` only in MEMWB with `result_src`=01.
- beq with `zero`=1 gives `pc_write`=1 in BRANCH; with `zero`=0 gives `pc_write`=0. bne with `zero`=0 gives `pc_write`=1. Each takes 3 cycles.
- sw: `mem_write` held through 3 wait cycles, drops the cycle after `mem_ready`=1. The next state is FETCH.
- Opcode 1110011: DECODE -> TRAP, `illegal`=1, with no enables for 10 cycles. Then `reset`=1 for 1 cycle returns to FETCH with `illegal`=0.
- `reset` asserted during MEMWRITE: `mem_write`=0 that cycle; the next state is FETCH.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller.
//   - state_e       : controller state, 4-bit encoding
//   - OP_*          : major opcodes (instr[6:0]) the controller understands
//   - FUNCT3_*      : branch funct3 values handled by BRANCH
//   - ALU_OP_*      : 2-bit code handed to the ALU decoder
//   - SRC_A_* / SRC_B_* / RES_* / IMM_* : datapath select encodings
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FUNCT3_BEQ = 3'b000;
    localparam logic [2:0] FUNCT3_BNE = 3'b001;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT   = 2'b00;
    localparam logic [1:0] RES_READ_DATA = 2'b01;
    localparam logic [1:0] RES_ALU_LIVE  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select, a pure function of the opcode.
//   opcode  : instr[6:0]
//   imm_src : 00 = I (also loads), 01 = S, 10 = B, 11 = J; unknown opcodes give I
module imm_src_decoder
    import core_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main controller: sequences each instruction through fetch,
// decode, execute, memory and writeback, driving datapath selects and
// write enables. Stalls on mem_ready; traps permanently on bad opcodes.
//   clk, reset        : clock, synchronous active-high reset
//   opcode, funct3    : instruction fields; zero: ALU zero flag
//   mem_ready         : memory finishes the current access this cycle
//   pc_write, ir_write, mem_write, reg_write : write enables
//   adr_src, alu_src_a, alu_src_b, result_src, alu_op, imm_src : selects
//   instr_done        : one-cycle retire pulse
//   illegal           : trap flag, held until reset
module main_control_fsm
    import core_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    state_e state_reg;
    state_e state_next;

    imm_src_decoder u_imm_src_decoder (
        .opcode  (opcode),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                    OP_RTYPE:          state_next = ST_EXECR;
                    OP_ITYPE:          state_next = ST_EXECI;
                    OP_BRANCH:         state_next = ST_BRANCH;
                    OP_JAL:            state_next = ST_JAL;
                    default:           state_next = ST_TRAP;
                endcase
            end
            ST_MEMADR:   state_next = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  if (mem_ready) state_next = ST_MEMWB;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_next = ST_FETCH;
            ST_EXECR:    state_next = ST_ALUWB;
            ST_EXECI:    state_next = ST_ALUWB;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_BRANCH: begin
                if (funct3 == FUNCT3_BEQ || funct3 == FUNCT3_BNE) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_TRAP;
                end
            end
            // JAL loads the target computed in DECODE, then ALUWB writes
            // the PC+4 that the ALU produces this cycle into rd.
            ST_JAL:      state_next = ST_ALUWB;
            ST_TRAP:     state_next = ST_TRAP;
            default:     state_next = ST_TRAP;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALU_OUT;
        alu_op     = ALU_OP_ADD;
        illegal    = 1'b0;
        unique case (state_reg)
            ST_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU_LIVE;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEMREAD:  adr_src = 1'b1;
            ST_MEMWB: begin
                result_src = RES_READ_DATA;
                reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_ALUWB:    reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_SUB;
                case (funct3)
                    FUNCT3_BEQ: pc_write = zero;
                    FUNCT3_BNE: pc_write = !zero;
                    default:    pc_write = 1'b0;
                endcase
            end
            ST_JAL: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            ST_TRAP:     illegal = 1'b1;
            default:     illegal = 1'b1;
        endcase

        instr_done = (state_reg != ST_FETCH) && (state_next == ST_FETCH);

        // Reset kills every side effect in the same cycle so an aborted
        // instruction cannot write anything at the reset edge.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm. Each task runs a list of cycles:
// inputs are driven at the falling edge and all outputs are compared 1 ns
// later against hand-computed packed vectors.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op, imm_src;
    logic       instr_done, illegal;

    int total = 0;
    int bad   = 0;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
    //  alu_src_b, result_src, alu_op, imm_src, instr_done, illegal}
    logic [16:0] obs;
    assign obs = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
                  alu_src_b, result_src, alu_op, imm_src, instr_done, illegal};

    typedef struct {
        logic        rst;
        logic        mr;
        logic        zero;
        logic [2:0]  f3;
        logic [16:0] exp;
    } step_t;

    function automatic logic [16:0] ev(input logic pcw, input logic irw, input logic mw,
                                       input logic rw, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [1:0] op, input logic [1:0] imm,
                                       input logic done, input logic ill);
        return {pcw, irw, mw, rw, adr, a, b, res, op, imm, done, ill};
    endfunction

    // FETCH: PC+4 on the live ALU result, enables follow mem_ready.
    function automatic logic [16:0] fv(input logic [1:0] imm, input logic mr);
        return ev(mr, mr, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    // DECODE: old PC + immediate.
    function automatic logic [16:0] dv(input logic [1:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    function automatic step_t st(input logic rst, input logic mr, input logic z,
                                 input logic [2:0] f3, input logic [16:0] exp);
        step_t s;
        s.rst = rst; s.mr = mr; s.zero = z; s.f3 = f3; s.exp = exp;
        return s;
    endfunction

    task automatic drive(input step_t s);
        @(negedge clk);
        reset     = s.rst;
        mem_ready = s.mr;
        zero      = s.zero;
        funct3    = s.f3;
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        int fails = 0;
        opcode = 7'b0110011;
        s.push_back(st(1, 1, 0, 3'b000, ev(0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,2'b00,0,0)));
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b00, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL reset step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("reset: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_add();
        step_t s[$];
        int fails = 0;
        opcode = 7'b0110011;
        s.push_back(st(0, 1, 0, 3'b000, fv(2'b00, 1)));
        s.push_back(st(0, 1, 0, 3'b000, dv(2'b00)));
        s.push_back(st(0, 1, 0, 3'b000, ev(0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,2'b00,0,0)));
        s.push_back(st(0, 1, 0, 3'b000, ev(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,0)));
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b00, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL add step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("add: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_addi();
        step_t s[$];
        int fails = 0;
        opcode = 7'b0010011;
        s.push_back(st(0, 1, 0, 3'b000, fv(2'b00, 1)));
        s.push_back(st(0, 0, 0, 3'b000, dv(2'b00)));
        s.push_back(st(0, 0, 0, 3'b000, ev(0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,2'b00,0,0)));
        s.push_back(st(0, 0, 0, 3'b000, ev(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,0)));
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b00, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL addi step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("addi: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_load_wait();
        step_t s[$];
        int fails = 0;
        opcode = 7'b0000011;
        s.push_back(st(0, 1, 0, 3'b010, fv(2'b00, 1)));
        s.push_back(st(0, 1, 0, 3'b010, dv(2'b00)));
        s.push_back(st(0, 1, 0, 3'b010, ev(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,2'b00,0,0)));
        s.push_back(st(0, 0, 0, 3'b010, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0)));
        s.push_back(st(0, 0, 0, 3'b010, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0)));
        s.push_back(st(0, 1, 0, 3'b010, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,0)));
        s.push_back(st(0, 1, 0, 3'b010, ev(0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,2'b00,1,0)));
        s.push_back(st(0, 0, 0, 3'b010, fv(2'b00, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL lw step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("lw: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_store_wait();
        step_t s[$];
        int fails = 0;
        opcode = 7'b0100011;
        s.push_back(st(0, 0, 0, 3'b010, fv(2'b01, 0)));
        s.push_back(st(0, 1, 0, 3'b010, fv(2'b01, 1)));
        s.push_back(st(0, 0, 0, 3'b010, dv(2'b01)));
        s.push_back(st(0, 1, 0, 3'b010, ev(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,2'b01,0,0)));
        for (int k = 0; k < 3; k++)
            s.push_back(st(0, 0, 0, 3'b010, ev(0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,2'b01,0,0)));
        s.push_back(st(0, 1, 0, 3'b010, ev(0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,2'b01,1,0)));
        s.push_back(st(0, 0, 0, 3'b010, fv(2'b01, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL sw step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("sw: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_branch();
        step_t s[$];
        int fails = 0;
        logic [2:0] f3v [4]  = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic       zv  [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       tak [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        opcode = 7'b1100011;
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(0, 1, zv[k], f3v[k], fv(2'b10, 1)));
            s.push_back(st(0, 1, zv[k], f3v[k], dv(2'b10)));
            s.push_back(st(0, 1, zv[k], f3v[k],
                           ev(tak[k],0,0,0,0,2'b10,2'b00,2'b00,2'b01,2'b10,1,0)));
        end
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b10, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL branch step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("branch: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_jal();
        step_t s[$];
        int fails = 0;
        opcode = 7'b1101111;
        s.push_back(st(0, 1, 0, 3'b000, fv(2'b11, 1)));
        s.push_back(st(0, 1, 0, 3'b000, dv(2'b11)));
        s.push_back(st(0, 1, 0, 3'b000, ev(1,0,0,0,0,2'b01,2'b10,2'b00,2'b00,2'b11,0,0)));
        s.push_back(st(0, 1, 0, 3'b000, ev(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b11,1,0)));
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b11, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL jal step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("jal: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_trap_opcode();
        step_t s[$];
        int fails = 0;
        opcode = 7'b1110011;
        s.push_back(st(0, 1, 0, 3'b000, fv(2'b00, 1)));
        s.push_back(st(0, 1, 0, 3'b000, dv(2'b00)));
        for (int k = 0; k < 10; k++)
            s.push_back(st(0, 1, 1, 3'b000, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,1)));
        s.push_back(st(1, 1, 0, 3'b000, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0)));
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b00, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL trap step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("trap opcode: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_branch_bad_funct3();
        step_t s[$];
        int fails = 0;
        opcode = 7'b1100011;
        s.push_back(st(0, 1, 1, 3'b100, fv(2'b10, 1)));
        s.push_back(st(0, 1, 1, 3'b100, dv(2'b10)));
        s.push_back(st(0, 1, 1, 3'b100, ev(0,0,0,0,0,2'b10,2'b00,2'b00,2'b01,2'b10,0,0)));
        s.push_back(st(0, 1, 1, 3'b100, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b10,0,1)));
        s.push_back(st(1, 1, 1, 3'b100, ev(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b10,0,0)));
        s.push_back(st(0, 0, 0, 3'b000, fv(2'b10, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL bad_funct3 step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("branch bad funct3: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    task automatic test_reset_in_memwrite();
        step_t s[$];
        int fails = 0;
        opcode = 7'b0100011;
        s.push_back(st(0, 1, 0, 3'b010, fv(2'b01, 1)));
        s.push_back(st(0, 1, 0, 3'b010, dv(2'b01)));
        s.push_back(st(0, 1, 0, 3'b010, ev(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,2'b01,0,0)));
        s.push_back(st(0, 0, 0, 3'b010, ev(0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,2'b01,0,0)));
        s.push_back(st(1, 1, 0, 3'b010, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b01,0,0)));
        s.push_back(st(0, 0, 0, 3'b010, fv(2'b01, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            total++;
            if (obs !== s[i].exp) begin
                bad++; fails++;
                $display("FAIL reset_memwrite step %0d: got %05h want %05h", i, obs, s[i].exp);
            end
        end
        $display("reset in memwrite: %0d cycles, %0d wrong", s.size(), fails);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 7'b0110011;
        funct3    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_add();
        test_addi();
        test_load_wait();
        test_store_wait();
        test_branch();
        test_jal();
        test_trap_opcode();
        test_branch_bad_funct3();
        test_reset_in_memwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
